// File: rtl/regfile_pkg.sv
// Shared constants for the Ember multi-port register file.
// Register-index helpers and default widths.
package regfile_pkg;

    localparam int DATA_W_DEF     = 64;
    localparam int REG_ADDR_W_DEF = 6;
    localparam int NUM_REGS_DEF   = 34;

    localparam logic [63:0] SP_RESET_DEF = 64'h0000_0000_0000_FFFF;

    localparam int REG_NULL = 0;

    function automatic int reg_sf(input int n);
        return n - 3;
    endfunction

    function automatic int reg_lr(input int n);
        return n - 2;
    endfunction

    function automatic int reg_sp(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: writes clear, issue sets, set wins.
// Ports: clk, rst, clr0/clr1 (effective write lanes), set, busy_o.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr0_en_i,
    input  logic [REG_ADDR_W-1:0] clr0_addr_i,
    input  logic                  clr1_en_i,
    input  logic [REG_ADDR_W-1:0] clr1_addr_i,
    input  logic                  set_en_i,
    input  logic [REG_ADDR_W-1:0] set_addr_i,
    output logic [NUM_REGS-1:0]   busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Index 0 is never touched by the loop, so NULL stays idle and
    // out-of-range set addresses match nothing.
    always_comb begin
        busy_d = busy_q;
        busy_d[REG_NULL] = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (clr0_en_i && clr0_addr_i == REG_ADDR_W'(i))
                busy_d[i] = 1'b0;
            if (clr1_en_i && clr1_addr_i == REG_ADDR_W'(i))
                busy_d[i] = 1'b0;
            if (set_en_i && set_addr_i == REG_ADDR_W'(i))
                busy_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Ember register file: two write lanes (lane 1 wins), NUM_RD read
// ports with optional write bypass, and an issue busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int          DATA_W     = DATA_W_DEF,
    parameter int          NUM_REGS   = NUM_REGS_DEF,
    parameter int          REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int          NUM_RD     = 3,
    parameter bit          BYPASS     = 1'b1,
    parameter logic [63:0] SP_RESET   = SP_RESET_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr0_en,
    input  logic [REG_ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]            wr0_data,
    input  logic                         wr1_en,
    input  logic [REG_ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]            wr1_data,
    input  logic [NUM_RD*REG_ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0]     rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         sb_set_en,
    input  logic [REG_ADDR_W-1:0]        sb_set_addr,
    output logic [NUM_REGS-1:0]          busy_vec
);

    localparam logic [REG_ADDR_W:0] NREGS = (REG_ADDR_W+1)'(NUM_REGS);
    localparam int SP_IDX = reg_sp(NUM_REGS);

    function automatic logic in_range(input logic [REG_ADDR_W-1:0] a);
        return (a != '0) && ({1'b0, a} < NREGS);
    endfunction

    logic wr0_eff;
    logic wr1_eff;

    assign wr0_eff = wr0_en && in_range(wr0_addr);
    assign wr1_eff = wr1_en && in_range(wr1_addr);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Lane 1 is applied last so it owns a shared destination.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wr0_eff && wr0_addr == REG_ADDR_W'(i))
                regs_d[i] = wr0_data;
            if (wr1_eff && wr1_addr == REG_ADDR_W'(i))
                regs_d[i] = wr1_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= (i == SP_IDX) ? SP_RESET[DATA_W-1:0]
                                           : '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .clr0_en_i   (wr0_eff),
        .clr0_addr_i (wr0_addr),
        .clr1_en_i   (wr1_eff),
        .clr1_addr_i (wr1_addr),
        .set_en_i    (sb_set_en),
        .set_addr_i  (sb_set_addr),
        .busy_o      (busy_vec)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     rd_stored;
        logic                  rd_sb;
        logic                  hit0;
        logic                  hit1;

        assign addr = rd_addr[k*REG_ADDR_W +: REG_ADDR_W];

        // NULL and out-of-range addresses match no entry and read 0.
        always_comb begin
            rd_stored = '0;
            rd_sb     = 1'b0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (addr == REG_ADDR_W'(i)) begin
                    rd_stored = regs_q[i];
                    rd_sb     = busy_vec[i];
                end
            end
        end

        assign hit1 = BYPASS && wr1_eff && (wr1_addr == addr);
        assign hit0 = BYPASS && wr0_eff && (wr0_addr == addr);

        assign rd_data[k*DATA_W +: DATA_W] =
            hit1 ? wr1_data :
            hit0 ? wr0_data : rd_stored;

        // A forwarded value is already the result, so no hazard.
        assign rd_busy[k] = rd_sb && !(hit0 || hit1);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: behavioural model plus
// directed literal checks on three configurations.
module tb_regfile_mp;

    localparam logic [63:0] SPR = 64'h0000_0000_0000_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr0_en, wr1_en, sb_set_en;
    logic [5:0]   wr0_addr, wr1_addr, sb_set_addr;
    logic [63:0]  wr0_data, wr1_data;
    logic [17:0]  rd_addr;
    logic [23:0]  rd_addr4;

    logic [191:0] rd_data, nb_rd_data;
    logic [2:0]   rd_busy, nb_rd_busy;
    logic [33:0]  busy_vec, nb_busy_vec, w4_busy_vec;
    logic [127:0] w4_rd_data;
    logic [3:0]   w4_rd_busy;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    regfile_mp u_dut (
        .clk(clk), .rst(rst),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .busy_vec(busy_vec)
    );

    regfile_mp #(.BYPASS(1'b0)) u_nb (
        .clk(clk), .rst(rst),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .busy_vec(nb_busy_vec)
    );

    regfile_mp #(.DATA_W(32), .NUM_RD(4)) u_w4 (
        .clk(clk), .rst(rst),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr),
        .wr0_data(wr0_data[31:0]),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr),
        .wr1_data(wr1_data[31:0]),
        .rd_addr(rd_addr4), .rd_data(w4_rd_data),
        .rd_busy(w4_rd_busy),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .busy_vec(w4_busy_vec)
    );

    // Behavioural model: architectural registers and busy flags.
    logic [63:0] m_regs [34];
    bit          m_busy [34];

    function automatic bit eff(input logic en, input logic [5:0] a);
        return en && a != 0 && a < 34;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 34; i++) begin
                m_regs[i] <= (i == 33) ? SPR : 64'd0;
                m_busy[i] <= 1'b0;
            end
        end else begin
            if (eff(wr0_en, wr0_addr)) begin
                m_regs[wr0_addr] <= wr0_data;
                m_busy[wr0_addr] <= 1'b0;
            end
            if (eff(wr1_en, wr1_addr)) begin
                m_regs[wr1_addr] <= wr1_data;
                m_busy[wr1_addr] <= 1'b0;
            end
            if (eff(sb_set_en, sb_set_addr))
                m_busy[sb_set_addr] <= 1'b1;
        end
    end

    function automatic logic [63:0] exp_rd(input logic [5:0] a,
                                           input bit byp);
        if (a == 0 || a >= 34) return 64'd0;
        if (byp && eff(wr1_en, wr1_addr) && wr1_addr == a)
            return wr1_data;
        if (byp && eff(wr0_en, wr0_addr) && wr0_addr == a)
            return wr0_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_rb(input logic [5:0] a,
                                    input bit byp);
        if (a == 0 || a >= 34) return 1'b0;
        if (byp && ((eff(wr1_en, wr1_addr) && wr1_addr == a) ||
                    (eff(wr0_en, wr0_addr) && wr0_addr == a)))
            return 1'b0;
        return m_busy[a];
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [5:0]  a;
            logic [63:0] e;
            logic [33:0] ev;
            for (int k = 0; k < 3; k++) begin
                a = rd_addr[k*6 +: 6];
                chk($sformatf("rd_data[%0d]", k),
                    rd_data[k*64 +: 64], exp_rd(a, 1'b1));
                chk($sformatf("nb_rd_data[%0d]", k),
                    nb_rd_data[k*64 +: 64], exp_rd(a, 1'b0));
                chk($sformatf("rd_busy[%0d]", k),
                    64'(rd_busy[k]), 64'(exp_rb(a, 1'b1)));
                chk($sformatf("nb_rd_busy[%0d]", k),
                    64'(nb_rd_busy[k]), 64'(exp_rb(a, 1'b0)));
            end
            for (int k = 0; k < 4; k++) begin
                a = rd_addr4[k*6 +: 6];
                e = exp_rd(a, 1'b1);
                chk($sformatf("w4_rd_data[%0d]", k),
                    64'(w4_rd_data[k*32 +: 32]), {32'd0, e[31:0]});
                chk($sformatf("w4_rd_busy[%0d]", k),
                    64'(w4_rd_busy[k]), 64'(exp_rb(a, 1'b1)));
            end
            for (int i = 0; i < 34; i++) ev[i] = m_busy[i];
            chk("busy_vec", 64'(busy_vec), 64'(ev));
            chk("nb_busy_vec", 64'(nb_busy_vec), 64'(ev));
            chk("w4_busy_vec", 64'(w4_busy_vec), 64'(ev));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en = 0; wr1_en = 0; sb_set_en = 0;
        wr0_addr = 0; wr1_addr = 0; sb_set_addr = 0;
        wr0_data = 0; wr1_data = 0;
    endtask

    task automatic late();
        @(negedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [5:0] a);
        rd_addr[p*6 +: 6] = a;
    endtask

    initial begin
        idle();
        rd_addr = '0;
        rd_addr4 = '0;
        // Reset with writes and a scoreboard set pending.
        rst = 1;
        wr0_en = 1; wr0_addr = 5; wr0_data = 64'hA;
        wr1_en = 1; wr1_addr = 33; wr1_data = 64'h55;
        sb_set_en = 1; sb_set_addr = 9;
        step();
        chk_en = 1'b1;
        rst = 0;
        idle();
        set_rd(0, 33); set_rd(1, 5); set_rd(2, 9);
        rd_addr4 = {6'd0, 6'd5, 6'd9, 6'd33};
        late();
        chk("lit_reset_sp", rd_data[63:0], 64'hFFFF);
        chk("lit_reset_r5", rd_data[127:64], 64'h0);
        chk("lit_reset_busy", 64'(busy_vec), 64'h0);
        chk("lit_w4_sp", 64'(w4_rd_data[31:0]), 64'hFFFF);

        // Same-address dual write: lane 1 wins.
        step();
        wr0_en = 1; wr0_addr = 5; wr0_data = 64'hA;
        wr1_en = 1; wr1_addr = 5; wr1_data = 64'hB;
        late();
        chk("lit_byp_r5", rd_data[127:64], 64'hB);
        chk("lit_nb_old_r5", nb_rd_data[127:64], 64'h0);
        step();
        idle();
        late();
        chk("lit_r5", rd_data[127:64], 64'hB);
        chk("lit_nb_r5", nb_rd_data[127:64], 64'hB);

        // Write to NULL and to an out-of-range index.
        step();
        wr0_en = 1; wr0_addr = 0; wr0_data = 64'h1;
        set_rd(0, 0);
        step();
        idle();
        wr1_en = 1; wr1_addr = 40; wr1_data = 64'hDEAD;
        sb_set_en = 1; sb_set_addr = 40;
        set_rd(1, 40);
        late();
        chk("lit_r0", rd_data[63:0], 64'h0);
        chk("lit_r40", rd_data[127:64], 64'h0);
        step();
        idle();
        late();
        chk("lit_r40_busy", 64'(busy_vec), 64'h0);

        // Bypass on port 2.
        step();
        set_rd(2, 7);
        wr1_en = 1; wr1_addr = 7; wr1_data = 64'h1234;
        late();
        chk("lit_byp_r7", rd_data[191:128], 64'h1234);
        chk("lit_nb_r7_old", nb_rd_data[191:128], 64'h0);
        step();
        idle();
        late();
        chk("lit_nb_r7_new", nb_rd_data[191:128], 64'h1234);

        // Scoreboard set / clear / set-wins.
        step();
        sb_set_en = 1; sb_set_addr = 9;
        set_rd(0, 9);
        late();
        chk("lit_busy9_pre", 64'(rd_busy[0]), 64'h0);
        step();
        idle();
        late();
        chk("lit_busy9_set", 64'(busy_vec[9]), 64'h1);
        chk("lit_rdbusy9", 64'(rd_busy[0]), 64'h1);
        step();
        wr0_en = 1; wr0_addr = 9; wr0_data = 64'h99;
        late();
        chk("lit_rdbusy9_fwd", 64'(rd_busy[0]), 64'h0);
        chk("lit_nb_rdbusy9", 64'(nb_rd_busy[0]), 64'h1);
        step();
        idle();
        late();
        chk("lit_busy9_clr", 64'(busy_vec[9]), 64'h0);
        step();
        sb_set_en = 1; sb_set_addr = 9;
        wr1_en = 1; wr1_addr = 9; wr1_data = 64'h77;
        step();
        idle();
        late();
        chk("lit_busy9_setwins", 64'(busy_vec[9]), 64'h1);

        // Distinct registers on every port.
        step();
        wr0_en = 1; wr0_addr = 1; wr0_data = 64'h11;
        wr1_en = 1; wr1_addr = 31; wr1_data = 64'h22;
        step();
        idle();
        wr0_en = 1; wr0_addr = 32; wr0_data = 64'h33;
        step();
        idle();
        set_rd(0, 1); set_rd(1, 31); set_rd(2, 32);
        rd_addr4 = {6'd33, 6'd32, 6'd31, 6'd1};
        late();
        chk("lit_p0", rd_data[63:0], 64'h11);
        chk("lit_p1", rd_data[127:64], 64'h22);
        chk("lit_p2", rd_data[191:128], 64'h33);
        chk("lit_w4_p0", 64'(w4_rd_data[31:0]), 64'h11);
        chk("lit_w4_p1", 64'(w4_rd_data[63:32]), 64'h22);
        chk("lit_w4_p2", 64'(w4_rd_data[95:64]), 64'h33);
        chk("lit_w4_p3", 64'(w4_rd_data[127:96]), 64'hFFFF);

        // Mixed traffic against the model.
        for (int i = 0; i < 60; i++) begin
            step();
            rst = (i == 30);
            wr0_en = 1'($urandom_range(0, 1));
            wr1_en = 1'($urandom_range(0, 1));
            sb_set_en = 1'($urandom_range(0, 1));
            wr0_addr = 6'($urandom_range(0, 40));
            wr1_addr = (i % 4 == 0) ? wr0_addr
                                    : 6'($urandom_range(0, 40));
            sb_set_addr = 6'($urandom_range(0, 40));
            wr0_data = {$urandom, $urandom};
            wr1_data = {$urandom, $urandom};
            for (int k = 0; k < 3; k++)
                set_rd(k, (k == 0) ? wr1_addr
                                   : 6'($urandom_range(0, 40)));
            for (int k = 0; k < 4; k++)
                rd_addr4[k*6 +: 6] = 6'($urandom_range(0, 40));
        end

        // Reset beats simultaneous writes and scoreboard set.
        step();
        rst = 1;
        wr0_en = 1; wr0_addr = 1; wr0_data = 64'hBAD;
        wr1_en = 1; wr1_addr = 33; wr1_data = 64'hBAD;
        sb_set_en = 1; sb_set_addr = 1;
        step();
        rst = 0;
        idle();
        set_rd(0, 1); set_rd(1, 33); set_rd(2, 5);
        late();
        chk("lit_rst2_r1", rd_data[63:0], 64'h0);
        chk("lit_rst2_sp", rd_data[127:64], 64'hFFFF);
        chk("lit_rst2_r5", rd_data[191:128], 64'h0);
        chk("lit_rst2_busy", 64'(busy_vec), 64'h0);

        step();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
